// File: rtl/mdio_hst_ctrl.sv
// MDIO host controller: configures the MAC after reset release, then issues queued MIIM commands.
// Optional build macro MDIO_HST_JUMBO_EN sets the Jumbo Enable bit in the RX/TX config words.
module mdio_hst_ctrl #(
    parameter int unsigned CMD_DEPTH  = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned TMO_W      = 16,
    parameter logic [4:0]  MDC_DIV    = 5'h09
) (
    input  logic        host_clk,
    input  logic        host_reset_n,
    input  logic        mac_rst,
    output logic [1:0]  host_opcode,
    output logic [9:0]  host_addr,
    output logic [31:0] host_wr_data,
    input  logic [31:0] host_rd_data,
    output logic        host_miim_sel,
    output logic        host_req,
    input  logic        host_miim_rdy,
    input  logic [31:0] acc_data,
    input  logic        acc_en,
    output logic        cmd_full,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        send_irq,
    output logic        tmo_err,
    output logic        ovf_err
);

`ifdef MDIO_HST_JUMBO_EN
    localparam logic JUMBO = 1'b1;
`else
    localparam logic JUMBO = 1'b0;
`endif

    localparam logic [31:0] RX_WORD  = 32'h1E00_0000 | {1'b0, JUMBO, 30'b0};
    localparam logic [31:0] TX_WORD  = 32'h1100_0000 | {1'b0, JUMBO, 30'b0};
    localparam logic [31:0] MGT_WORD = {26'b0, 1'b1, MDC_DIV};

    localparam int unsigned AW = $clog2(CMD_DEPTH);
    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam logic [AW:0]      FULL_CNT    = (AW + 1)'(CMD_DEPTH);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = {{(TMO_W - 1){1'b1}}, 1'b0};

    typedef enum logic [3:0] {
        RST, WAIT_MAC, SETTLE, CFG_RX, GAP_RX, CFG_TX, GAP_TX,
        CFG_MGT, GAP_MGT, IDLE, ISSUE, WAIT_RDY
    } state_t;

    state_t state, next_state;

    logic            mac_meta, mac_s;
    logic [SW-1:0]   settle_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [27:0]     cmd_q;
    logic            cfg_done;

    logic [27:0]     mem [CMD_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [27:0]     head;
    logic            full, empty, flush, push_ok, push_drop, pop;
    logic            done_ok, tmo_hit;

    logic unused_bits;
    assign unused_bits = ^{acc_data[31:28], host_rd_data[31:16]};

    always_ff @(posedge host_clk or negedge host_reset_n) begin
        if (!host_reset_n) begin
            mac_meta <= 1'b0;
            mac_s    <= 1'b0;
        end else begin
            mac_meta <= mac_rst;
            mac_s    <= mac_meta;
        end
    end

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_full  = full;
    assign head      = mem[rd_ptr];
    assign flush     = (state != RST) && mac_s;
    assign push_ok   = acc_en && cfg_done && !full && !flush;
    assign push_drop = acc_en && cfg_done && full && !flush;

    always_ff @(posedge host_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= acc_data[27:0];
        end
    end

    always_ff @(posedge host_clk or negedge host_reset_n) begin
        if (!host_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        next_state    = state;
        host_opcode   = 2'b11;
        host_addr     = '0;
        host_wr_data  = '0;
        host_miim_sel = 1'b0;
        host_req      = 1'b0;
        pop           = 1'b0;
        done_ok       = 1'b0;
        tmo_hit       = 1'b0;
        case (state)
            RST:      next_state = WAIT_MAC;
            WAIT_MAC: if (!mac_s) next_state = SETTLE;
            SETTLE:   if (settle_cnt == SETTLE_LAST) next_state = CFG_RX;
            CFG_RX: begin
                host_opcode  = 2'b01;
                host_addr    = 10'h240;
                host_wr_data = RX_WORD;
                next_state   = GAP_RX;
            end
            GAP_RX:   next_state = CFG_TX;
            CFG_TX: begin
                host_opcode  = 2'b01;
                host_addr    = 10'h280;
                host_wr_data = TX_WORD;
                next_state   = GAP_TX;
            end
            GAP_TX:   next_state = CFG_MGT;
            CFG_MGT: begin
                host_opcode  = 2'b01;
                host_addr    = 10'h340;
                host_wr_data = MGT_WORD;
                next_state   = GAP_MGT;
            end
            GAP_MGT:  next_state = IDLE;
            IDLE: begin
                host_miim_sel = 1'b1;
                if (!empty && host_miim_rdy) next_state = ISSUE;
            end
            ISSUE: begin
                host_miim_sel = 1'b1;
                host_opcode   = head[27:26];
                host_addr     = head[25:16];
                host_wr_data  = {16'b0, head[15:0]};
                host_req      = 1'b1;
                pop           = 1'b1;
                next_state    = WAIT_RDY;
            end
            WAIT_RDY: begin
                host_miim_sel = 1'b1;
                host_opcode   = cmd_q[27:26];
                host_addr     = cmd_q[25:16];
                host_wr_data  = {16'b0, cmd_q[15:0]};
                if (host_miim_rdy) begin
                    done_ok    = 1'b1;
                    next_state = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit    = 1'b1;
                    next_state = IDLE;
                end
            end
            default:  next_state = RST;
        endcase
        // MAC reset overrides whatever the current state decided, including any pop/completion.
        if (flush) begin
            next_state    = WAIT_MAC;
            host_opcode   = 2'b11;
            host_addr     = '0;
            host_wr_data  = '0;
            host_miim_sel = 1'b0;
            host_req      = 1'b0;
            pop           = 1'b0;
            done_ok       = 1'b0;
            tmo_hit       = 1'b0;
        end
    end

    always_ff @(posedge host_clk or negedge host_reset_n) begin
        if (!host_reset_n) begin
            state      <= RST;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            cmd_q      <= '0;
            cfg_done   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            send_irq   <= 1'b0;
            tmo_err    <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            state      <= next_state;
            settle_cnt <= (state == SETTLE && next_state == SETTLE) ? settle_cnt + 1'b1 : '0;
            tmo_cnt    <= (state == WAIT_RDY) ? tmo_cnt + 1'b1 : '0;
            if (pop) cmd_q <= head;
            if (state == GAP_MGT && next_state == IDLE) cfg_done <= 1'b1;
            rd_valid <= done_ok && cmd_q[27];
            send_irq <= done_ok || tmo_hit;
            if (done_ok && cmd_q[27]) rd_data <= host_rd_data[15:0];
            if (tmo_hit)   tmo_err <= 1'b1;
            if (push_drop) ovf_err <= 1'b1;
        end
    end

endmodule

// File: doc/mdio_hst_ctrl.md
MDIO_HST_CTRL -- requirements
Module: mdio_hst_ctrl

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 4, meaning MDIO command FIFO depth; power of 2, at least 2.
REQ-002 SHALL have parameter SETTLE_CYC, default 8, meaning cycles waited after MAC reset release before configuration.
REQ-003 SHALL have parameter TMO_W, default 16, meaning width of the host_miim_rdy timeout counter.
REQ-004 SHALL have parameter MDC_DIV, default 5'h09, meaning the MDIO clock-divide field of the management word.
REQ-005 SHALL have ports (name, direction, width, meaning): host_clk in 1 sole clock; host_reset_n in 1 async active-low reset; mac_rst in 1 async MAC reset, active-high.
REQ-006 SHALL have MAC host-bus ports: host_opcode out 2; host_addr out 10; host_wr_data out 32; host_rd_data in 32; host_miim_sel out 1; host_req out 1; host_miim_rdy in 1.
REQ-007 SHALL have command ports: acc_data in 32 (opcode [27:26], addr [25:16], data [15:0]); acc_en in 1 single-cycle push; cmd_full out 1.
REQ-008 SHALL have status ports: rd_data out 16; rd_valid out 1 pulse; send_irq out 1 pulse; tmo_err out 1 sticky; ovf_err out 1 sticky.

Function
REQ-009 SHALL synchronise mac_rst through two host_clk flops before use.
REQ-010 SHALL use FSM states RST, WAIT_MAC, SETTLE, CFG_RX, GAP_RX, CFG_TX, GAP_TX, CFG_MGT, GAP_MGT, IDLE, ISSUE, WAIT_RDY.
REQ-011 SHALL leave RST after one cycle to WAIT_MAC, then go to SETTLE once synced mac_rst is low, then to CFG_RX after exactly SETTLE_CYC cycles in SETTLE.
REQ-012 SHALL, in each CFG_* state, drive for one cycle host_opcode=2'b01, host_miim_sel=0 and host_req=0, with host_addr 0x240 (RX), 0x280 (TX) or 0x340 (MGT).
REQ-013 SHALL use RX word 0x1E000000, TX word 0x11000000, and MGT word {26'b0, 1'b1, MDC_DIV}.
REQ-014 SHALL, in each GAP_* state, drive the idle bus: opcode 2'b11, addr 0, wr_data 0, miim_sel 0, req 0.
REQ-015 SHALL, in IDLE, hold host_miim_sel=1 and the idle bus, and go to ISSUE when the FIFO is non-empty and host_miim_rdy=1.
REQ-016 SHALL, in ISSUE, pop one command and drive opcode, addr and wr_data={16'b0,data} with host_req=1 for exactly one cycle, then go to WAIT_RDY.
REQ-017 SHALL hold opcode, addr and wr_data stable through WAIT_RDY.
REQ-018 SHALL, when WAIT_RDY sees host_miim_rdy=1, pulse send_irq and return to IDLE; for opcode[1]=1 it SHALL also load rd_data=host_rd_data[15:0] and pulse rd_valid in the same cycle.
REQ-019 SHALL count WAIT_RDY cycles and, on reaching 2^TMO_W-1 without rdy, set tmo_err, pulse send_irq, leave rd_valid low and return to IDLE.
REQ-020 SHALL treat the FIFO as CMD_DEPTH x 28 bits, first-in first-out; the 4 MSBs of acc_data are ignored.
REQ-021 SHALL accept acc_en only when the occupancy at the start of the cycle is below CMD_DEPTH; a push while full is dropped and sets ovf_err.
REQ-022 SHALL allow push and pop in the same cycle, occupancy unchanged; pointers wrap modulo CMD_DEPTH.
REQ-023 SHALL drive cmd_full = (occupancy == CMD_DEPTH).
REQ-024 SHALL, if synced mac_rst is high in any state after RST, flush the FIFO, drive the idle bus with miim_sel=0, and go to WAIT_MAC; the full configuration sequence then reruns.
REQ-025 SHALL drop acc_en pushes before the first entry to IDLE, without setting ovf_err.
REQ-026 SHALL clear tmo_err and ovf_err only by host_reset_n.

Reset
REQ-027 SHALL, while host_reset_n=0, asynchronously force state RST, opcode 2'b11, addr 0, wr_data 0, miim_sel 0, req 0, rd_data 0, rd_valid 0, send_irq 0, tmo_err 0, ovf_err 0, an empty FIFO, cmd_full 0 and sync flops 0.
REQ-028 SHALL restart the FSM in RST after reset release.

Configuration
REQ-029 SHALL, with MDIO_HST_JUMBO_EN defined, set bit 30 (Jumbo Enable) in the RX and TX words, giving 0x5E000000 and 0x51000000.
REQ-030 SHALL, without MDIO_HST_JUMBO_EN, keep bit 30 at 0 in both words (values per REQ-013).

Verification
REQ-031 SHALL cover: reset release with mac_rst=0 -> three one-cycle writes, 0x240/0x1E000000, 0x280/0x11000000, 0x340/0x00000029, each followed by one idle cycle.
REQ-032 SHALL cover: push 0x08012345 (read) and return rdy after 10 cycles with host_rd_data=0x0000BEEF -> one host_req pulse, opcode 2'b10, addr 0x001; rd_data=0xBEEF; rd_valid and send_irq pulse together.
REQ-033 SHALL cover: push 5 commands back-to-back with CMD_DEPTH=4 and rdy held low -> cmd_full=1 after 4, 5th dropped, ovf_err=1; the 4 issue in order once rdy rises.
REQ-034 SHALL cover: TMO_W=4 and rdy stuck low after ISSUE -> tmo_err=1 and send_irq pulse after 15 WAIT_RDY cycles, no rd_valid, next command issued.
REQ-035 SHALL cover: assert mac_rst mid-WAIT_RDY with 2 commands queued -> FIFO empty, miim_sel=0; after mac_rst release the configuration writes repeat.
REQ-036 SHALL cover: build with MDIO_HST_JUMBO_EN -> RX word 0x5E000000, TX word 0x51000000.
